// File: rtl/fwd_pkg.sv
// fwd_pkg: shared tracking-entry type, stage indices and select-width helper for the forwarding unit.
package fwd_pkg;

    // Destination field is stored zero-extended so any ADDR_W up to this fits one entry type.
    localparam int DEST_MAX = 16;

    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;

    typedef struct packed {
        logic                valid;
        logic                writereg;
        logic                load;
        logic [DEST_MAX-1:0] dest;
    } fwd_entry_t;

    function automatic int sel_width(input int nstage);
        return $clog2(nstage + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// fwd_match: one source operand's comparator chain over the tracked stages, youngest-wins mux and sel encoding.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NSTAGE = 3,
    parameter int SEL_W  = 2
) (
    input  fwd_entry_t [NSTAGE-1:0]        tab,
    input  logic       [ADDR_W-1:0]        addr,
    input  logic       [DATA_W-1:0]        regval,
    input  logic       [NSTAGE*DATA_W-1:0] stage_wbvalue,
    output logic       [DATA_W-1:0]        value,
    output logic       [SEL_W-1:0]         sel,
    output logic                           win_load
);

    logic [NSTAGE-1:0] hit;

    // Walk oldest to youngest so the youngest matching producer is the last to overwrite.
    always_comb begin
        hit      = '0;
        value    = regval;
        sel      = '0;
        win_load = 1'b0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            hit[k] = tab[k].valid && tab[k].writereg && tab[k].dest == DEST_MAX'(addr) && addr != '0;
            if (hit[k]) begin
                value    = stage_wbvalue[k*DATA_W +: DATA_W];
                sel      = SEL_W'(k + 1);
                win_load = tab[k].load;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: decode-stage operand forwarding and load-use stall over NSTAGE tracked stages.
// Define FWD_STATS_EN to add saturating forward/stall event counters.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NSRC   = 2,
    parameter int NSTAGE = 3
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 id_valid,
    input  logic [ADDR_W-1:0]                    id_regdest,
    input  logic                                 id_writereg,
    input  logic                                 id_load,
    input  logic [NSRC*ADDR_W-1:0]               id_addr,
    input  logic [NSRC*DATA_W-1:0]               id_regval,
    input  logic [NSTAGE*DATA_W-1:0]             stage_wbvalue,
    input  logic                                 freeze,
    output logic [NSRC*DATA_W-1:0]               fw_id_regval,
    output logic [NSRC*sel_width(NSTAGE)-1:0]    fw_src_sel,
    output logic                                 fw_if_id_stall
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]                          fw_stat_fwd,
    output logic [31:0]                          fw_stat_stall
`endif
);

    localparam int SEL_W = sel_width(NSTAGE);

    fwd_entry_t [NSTAGE-1:0] tab;
    logic [NSRC*DATA_W-1:0]  res_val;
    logic [NSRC*SEL_W-1:0]   res_sel;
    logic [NSRC-1:0]         ld_hit;
    logic [NSRC-1:0]         fwd_hit;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        logic [SEL_W-1:0] sel;
        logic             win_load;
        fwd_match #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W),
            .NSTAGE(NSTAGE),
            .SEL_W (SEL_W)
        ) u_match (
            .tab          (tab),
            .addr         (id_addr[i*ADDR_W +: ADDR_W]),
            .regval       (id_regval[i*DATA_W +: DATA_W]),
            .stage_wbvalue(stage_wbvalue),
            .value        (res_val[i*DATA_W +: DATA_W]),
            .sel          (sel),
            .win_load     (win_load)
        );
        assign res_sel[i*SEL_W +: SEL_W] = sel;
        // An EX-stage hit always wins, so a winning load in EX is exactly a load-use pair.
        assign ld_hit[i]  = win_load && sel == SEL_W'(STG_EX + 1);
        assign fwd_hit[i] = sel != '0;
    end

    assign fw_if_id_stall = id_valid && |ld_hit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tab          <= '0;
            fw_id_regval <= '0;
            fw_src_sel   <= '0;
        end else if (!freeze) begin
            for (int k = NSTAGE - 1; k > 0; k--) tab[k] <= tab[k-1];
            tab[STG_EX] <= fw_if_id_stall ? '0
                         : fwd_entry_t'{id_valid, id_writereg, id_load, DEST_MAX'(id_regdest)};
            if (!fw_if_id_stall) begin
                fw_id_regval <= res_val;
                fw_src_sel   <= res_sel;
            end
        end
    end

`ifdef FWD_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fw_stat_fwd   <= '0;
            fw_stat_stall <= '0;
        end else if (!freeze) begin
            if (!fw_if_id_stall && |fwd_hit && fw_stat_fwd != '1) fw_stat_fwd <= fw_stat_fwd + 32'd1;
            if (fw_if_id_stall && fw_stat_stall != '1) fw_stat_stall <= fw_stat_stall + 32'd1;
        end
    end
`else
    logic unused_fwd_hit;
    assign unused_fwd_hit = ^fwd_hit;
`endif

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the decode-stage forwarding unit.
- Tracks destination registers of in-flight instructions across NSTAGE downstream stages (EX, MEM, WB, ...) and forwards the youngest matching writeback value to each of NSRC decode source operands.
- Raises a load-use stall and inserts a bubble into its tracking pipeline.
- Adds capabilities the previous unit lacked: register-zero suppression, per-entry valid/writereg/load tracking, external freeze, and per-operand source-select reporting.

Parameters:
- DATA_W, 32, operand/writeback data width
- ADDR_W, 5, register address width
- NSRC, 2, number of decode source operands
- NSTAGE, 3, tracked downstream stages; index 0 = EX (youngest), NSTAGE-1 = oldest (WB)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  decode holds a real instruction
- id_regdest  in  ADDR_W  decode destination register
- id_writereg  in  1  decode instruction writes a register
- id_load  in  1  decode instruction is a load
- id_addr  in  NSRC*ADDR_W  source addresses; operand i at bits [i*ADDR_W +: ADDR_W]
- id_regval  in  NSRC*DATA_W  register-file read values, same packing
- stage_wbvalue  in  NSTAGE*DATA_W  writeback value currently held by each stage k
- freeze  in  1  global pipeline hold (e.g. memory wait)
- fw_id_regval  out  NSRC*DATA_W  registered resolved operands to EX
- fw_src_sel  out  NSRC*(clog2(NSTAGE+1))  registered source per operand: 0 = register file, k+1 = stage k
- fw_if_id_stall  out  1  combinational stall request to PC/fetch/decode

Behaviour:
- Table T[0..NSTAGE-1], each entry {valid, writereg, load, dest}.
- Reset (reset low, async): all T entries invalid; fw_id_regval = 0; fw_src_sel = 0; fw_if_id_stall = 0. Reset mid-stall drops the stall immediately.
- Match, operand i against stage k: T[k].valid && T[k].writereg && T[k].dest == addr_i && addr_i != 0.
- Priority: lowest k wins (youngest producer). With no match, use id_regval. Register 0 is never forwarded and always takes id_regval.
- Stall (combinational): id_valid && any operand matches T[0] && T[0].load. Stall lasts exactly 1 cycle per load-use pair, because the load has moved to T[1] on the next edge.
- Clock edge, freeze=1: T, fw_id_regval and fw_src_sel hold. Stall is still reported. Freeze has priority over stall.
- Clock edge, freeze=0, stall=1:
  - T shifts (T[k] <= T[k-1]).
  - T[0] <= bubble (valid=0).
  - fw outputs hold their previous value; EX treats the cycle as a bubble.
- Clock edge, freeze=0, stall=0:
  - T shifts.
  - T[0] <= {id_valid, id_writereg, id_load, id_regdest}.
  - fw_id_regval/fw_src_sel <= resolved values computed from pre-shift T and current stage_wbvalue.
- Latency: 1 cycle from decode inputs to fw outputs.
- Oldest entry T[NSTAGE-1] is discarded on shift. There is no wrap-around.
- id_valid=0 enters T as invalid and never stalls.
- Both operands may match different stages; each resolves independently. Both matching the same stage is legal.

Optional Feature:
- FWD_STATS_EN defined: adds outputs fw_stat_fwd (32-bit count of clock edges that captured at least one forwarded operand) and fw_stat_stall (32-bit count of stall cycles not masked by freeze).
  - Both counters are zeroed by reset and saturate at all-ones.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fwd_pkg holds:
  - typedef fwd_entry_t {valid, writereg, load, dest}
  - constants STG_EX=0, STG_MEM=1, STG_WB=2
  - function for SEL_W = clog2(NSTAGE+1)
- Sub-module fwd_match: one operand's comparator chain, priority mux and sel encoding; instantiated NSRC times by a generate loop.

Test Plan:
- Back-to-back ALU: r3 <= r1+r2, then r4 <= r3+r5; stage_wbvalue[0]=0x0000_00AA -> fw_id_regval op0 = 0xAA, fw_src_sel op0 = 1, no stall.
- Priority: r7 written in both EX (0x11) and WB (0x33); decode reads r7 -> 0x11 selected, sel = 1.
- Load-use: lw r8 followed by add r9,r8,r8 -> stall high 1 cycle, T[0] bubble, next edge op0 = op1 = stage_wbvalue[1], sel = 2.
- Register zero: EX entry dest=0 with writereg=1; decode reads r0 with id_regval=0 -> output 0, sel = 0.
- Freeze during load-use stall for 3 cycles -> T and outputs hold, stall stays high; after release, a single bubble is inserted.
- Reset asserted mid-stall -> stall drops asynchronously, outputs 0, all entries invalid. First instruction after release resolves from id_regval.
